// File: rtl/jtag_user_dr_sync.sv
// jtag_user_dr_sync
// System-clock-side consumer of the Gowin JTAG primitive's ER1 user-register
// outputs. The raw JTAG signals are oversampled through synchroniser flops.
// A DR_WIDTH-bit user data register captures a parallel word and shifts it
// out on TDO LSB-first while TDI is shifted in. On Update-DR the shifted-in
// word is presented on a valid/ready port.
//
// Ports
//   clk                 system clock, at least 8x the TCK frequency
//   reset               asynchronous, active-high reset
//   jtag_tck            tck_o from the primitive
//   jtag_tdi            tdi_o
//   jtag_tlr            test_logic_reset_o
//   jtag_shift_capture  shift_dr_capture_dr_o
//   jtag_update         update_dr_o
//   jtag_enable         enable_er1_o
//   jtag_tdo            to tdo_er1_i, bit 0 of the shift register
//   cap_data            word loaded into the register at capture
//   cap_strobe          one-clk pulse when cap_data is sampled
//   upd_data            shifted-in word
//   upd_bits            number of TDI bits shifted, saturating at DR_WIDTH
//   upd_valid           word pending
//   upd_ready           consumer accepts when upd_valid & upd_ready
//   overrun             sticky: an update replaced an unaccepted word
module jtag_user_dr_sync #(
    parameter int DR_WIDTH    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              jtag_tck,
    input  logic                              jtag_tdi,
    input  logic                              jtag_tlr,
    input  logic                              jtag_shift_capture,
    input  logic                              jtag_update,
    input  logic                              jtag_enable,
    output logic                              jtag_tdo,
    input  logic [DR_WIDTH-1:0]               cap_data,
    output logic                              cap_strobe,
    output logic [DR_WIDTH-1:0]               upd_data,
    output logic [$clog2(DR_WIDTH+1)-1:0]     upd_bits,
    output logic                              upd_valid,
    input  logic                              upd_ready,
    output logic                              overrun
);

    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT
    } state_t;

    // Synchroniser chain; all six JTAG inputs travel together as one vector.
    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic tck_s, tdi_s, tlr_s, shift_s, upd_s, en_s;
    logic tck_d, shift_d, upd_d;
    logic tck_rise, shift_rise, upd_rise;

    state_t state_q, state_d;
    logic   load_cap, do_shift, do_update;

    logic [DR_WIDTH-1:0] sr_q;
    logic [CNT_W-1:0]    count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0],
                       {jtag_tck, jtag_tdi, jtag_tlr, jtag_shift_capture, jtag_update, jtag_enable}};
        end
    end

    assign {tck_s, tdi_s, tlr_s, shift_s, upd_s, en_s} = sync_q[SYNC_STAGES-1];

    // Previous synced values, for edge detection between consecutive clks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_d   <= 1'b0;
            shift_d <= 1'b0;
            upd_d   <= 1'b0;
        end else begin
            tck_d   <= tck_s;
            shift_d <= shift_s;
            upd_d   <= upd_s;
        end
    end

    assign tck_rise   = tck_s & ~tck_d;
    assign shift_rise = shift_s & ~shift_d;
    assign upd_rise   = upd_s & ~upd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first TCK rise after capture is the Capture-DR clock itself, so
    // CAPTURE waits for it without shifting. Enable low or TLR high abort
    // the scan from any state but leave the register contents alone.
    always_comb begin
        state_d  = state_q;
        load_cap = 1'b0;
        do_shift = 1'b0;
        if (!en_s || tlr_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (shift_rise) begin
                        state_d  = CAPTURE;
                        load_cap = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!shift_s) begin
                        state_d = IDLE;
                    end else if (tck_rise) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!shift_s) begin
                        state_d = IDLE;
                    end else if (tck_rise) begin
                        do_shift = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // An update mid-capture is ignored; a zero-shift scan still updates.
    assign do_update = upd_rise & en_s & (state_q != CAPTURE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q       <= '0;
            count_q    <= '0;
            cap_strobe <= 1'b0;
        end else begin
            cap_strobe <= load_cap;
            if (load_cap) begin
                sr_q    <= cap_data;
                count_q <= '0;
            end else if (do_shift) begin
                sr_q <= {tdi_s, sr_q[DR_WIDTH-1:1]};
                if (count_q != CNT_W'(DR_WIDTH)) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    // An update in the same clk as acceptance replaces the consumed word
    // without flagging overrun; only an unaccepted word is counted as lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_data  <= '0;
            upd_bits  <= '0;
            upd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_update) begin
                upd_data  <= sr_q;
                upd_bits  <= count_q;
                upd_valid <= 1'b1;
                if (upd_valid && !upd_ready) begin
                    overrun <= 1'b1;
                end
            end else if (upd_valid && upd_ready) begin
                upd_valid <= 1'b0;
            end
        end
    end

    assign jtag_tdo = sr_q[0];

endmodule
